// File: rtl/apb_slave_pkg.sv
// Shared types and helpers for the APB3 memory completer.
package apb_slave_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Word 0 holds the read-only identification word.
    localparam int unsigned ID_INDEX   = 0;
    // Byte address to word index.
    localparam int unsigned WORD_SHIFT = 2;

    // A transfer is in error when it is misaligned, outside storage,
    // or attempts to overwrite the ID word.
    function automatic logic apb_err(input logic [31:0] addr,
                                     input logic        wr,
                                     input int unsigned depth);
        logic [31:0] idx;
        idx = addr >> WORD_SHIFT;
        return (addr[1:0] != 2'b00) || (idx >= depth) || (wr && (idx == ID_INDEX));
    endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// Word storage: synchronous write, asynchronous read, synchronous clear.
module apb_slave_regfile #(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_clr,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_widx,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [IDX_W-1:0]      i_ridx,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Clear wins over a write landing on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_widx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/apb3_slave_mem.sv
// APB3 completer in front of a word register file with a fixed ID word
// and a configurable number of wait states per transfer.
//
// Handshake: a transfer is captured when PSEL=1 and PENABLE=0 are seen in
// IDLE; it completes in the single cycle where PREADY=1, which requires the
// FSM in ACCESS with the wait counter exhausted and PSEL=PENABLE=1. PRDATA
// and PSLVERR are meaningful only in that cycle; dropping PSEL before it
// abandons the transfer with no side effects.
module apb3_slave_mem
    import apb_slave_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH       = 64,
    parameter int                    WAIT_CYCLES = 2,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA9B3_0001
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [1:0]            o_dbg_state
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  w_start;
    logic                  w_ready;
    logic                  w_err;
    logic                  w_we;
    logic [IDX_W-1:0]      w_idx;
    logic [DATA_WIDTH-1:0] w_mem_rdata;

    assign w_start = (r_state == IDLE) && PSEL && !PENABLE;
    assign w_ready = (r_state == ACCESS) && (r_cnt == '0) && PSEL && PENABLE;
    assign w_err   = apb_err(32'(r_addr), r_write, DEPTH);
    assign w_idx   = r_addr[IDX_W+1:WORD_SHIFT];
    assign w_we    = w_ready && r_write && !w_err;

    // State register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic. A completed transfer returns to IDLE; a following
    // setup phase is presented in that same IDLE cycle and is captured on the
    // next edge, so back-to-back transfers need no extra bubble.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (PSEL && !PENABLE) w_next = SETUP;
            SETUP:   w_next = ACCESS;
            ACCESS:  if (!PSEL || w_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Capture the request at setup and count down wait states in ACCESS.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
        end else if (w_start) begin
            r_cnt   <= CNT_W'(WAIT_CYCLES);
            r_addr  <= PADDR;
            r_write <= PWRITE;
            r_wdata <= PWDATA;
        end else if ((r_state == ACCESS) && PSEL && PENABLE && (r_cnt != '0)) begin
            r_cnt   <= r_cnt - CNT_W'(1);
        end
    end

    apb_slave_regfile #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_regfile (
        .i_clk   (PCLK),
        .i_clr   (PRESET),
        .i_we    (w_we),
        .i_widx  (w_idx),
        .i_wdata (r_wdata),
        .i_ridx  (w_idx),
        .o_rdata (w_mem_rdata)
    );

    // Read data only on a good read completion; zero everywhere else.
    always_comb begin
        PRDATA = '0;
        if (w_ready && !r_write && !w_err) begin
            PRDATA = (w_idx == IDX_W'(ID_INDEX)) ? ID_VALUE : w_mem_rdata;
        end
    end

    assign PREADY      = w_ready;
    assign PSLVERR     = w_ready && w_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb3_slave_mem.sv
// Directed bench for apb3_slave_mem: one instance with two wait states and
// one zero-wait instance sharing the bus; use0 selects which one is driven.
module tb_apb3_slave_mem;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [31:0] ID_WORD = 32'hA9B3_0001;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [9:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic        use0 = 1'b0;

    logic [31:0] prdata2, prdata0, prdata;
    logic        pready2, pready0, pready;
    logic        pslverr2, pslverr0, pslverr;
    logic [1:0]  dbg2, dbg0, dbg;

    int checks = 0;
    int failures = 0;

    always #5 pclk = ~pclk;

    apb3_slave_mem #(
        .ADDR_WIDTH (10), .DATA_WIDTH (32), .DEPTH (64),
        .WAIT_CYCLES (2), .ID_VALUE (32'hA9B3_0001)
    ) u_dut (
        .PCLK (pclk), .PRESET (preset), .PSEL (psel && !use0), .PENABLE (penable),
        .PWRITE (pwrite), .PADDR (paddr), .PWDATA (pwdata),
        .PRDATA (prdata2), .PREADY (pready2), .PSLVERR (pslverr2), .o_dbg_state (dbg2)
    );

    apb3_slave_mem #(
        .ADDR_WIDTH (10), .DATA_WIDTH (32), .DEPTH (64),
        .WAIT_CYCLES (0), .ID_VALUE (32'hA9B3_0001)
    ) u_dut0 (
        .PCLK (pclk), .PRESET (preset), .PSEL (psel && use0), .PENABLE (penable),
        .PWRITE (pwrite), .PADDR (paddr), .PWDATA (pwdata),
        .PRDATA (prdata0), .PREADY (pready0), .PSLVERR (pslverr0), .o_dbg_state (dbg0)
    );

    assign prdata  = use0 ? prdata0  : prdata2;
    assign pready  = use0 ? pready0  : pready2;
    assign pslverr = use0 ? pslverr0 : pslverr2;
    assign dbg     = use0 ? dbg0     : dbg2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transfer. exp_acc is the number of cycles spent in the
    // ACCESS state up to and including the PREADY cycle. With scr set, the
    // bus address/data are disturbed once the access phase starts.
    task automatic xfer(input string tag, input logic wr, input logic [9:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err, input int exp_acc, input logic scr);
        logic [31:0] rd;
        logic        err;
        logic        done;
        int          acc;
        rd = '0; err = 1'b0; done = 1'b0; acc = 0;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        @(posedge pclk); #1;
        penable = 1'b1;
        if (scr) begin
            paddr  = addr ^ 10'h00C;
            pwdata = ~wd;
        end
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge pclk);
            if (dbg == S_ACCESS) acc++;
            if (pready) begin
                done = 1'b1;
                rd   = prdata;
                err  = pslverr;
            end
            @(posedge pclk); #1;
        end
        psel = 1'b0; penable = 1'b0;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_acc"}, 32'(acc), 32'(exp_acc));
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        if (!wr) chk({tag, "_rdata"}, rd, exp_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle bus.
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        chk("rst_pready", 32'(pready), 32'd0);
        chk("rst_pslverr", 32'(pslverr), 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_state", 32'(dbg), 32'(S_IDLE));
        @(posedge pclk); #1;
        preset = 1'b0;
        // Access phase without setup is ignored.
        penable = 1'b1;
        @(posedge pclk); #1;
        penable = 1'b0;
        @(negedge pclk);
        chk("idle_pready", 32'(pready), 32'd0);
        chk("idle_noenter", 32'(dbg), 32'(S_IDLE));
        @(posedge pclk); #1;

        xfer("rd_04", 1'b0, 10'h004, 32'h0, 32'h0000_0000, 1'b0, 3, 1'b0);
        xfer("wr_10", 1'b1, 10'h010, 32'hDEAD_BEEF, 32'h0, 1'b0, 3, 1'b0);
        xfer("rd_10", 1'b0, 10'h010, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 1'b0);
        xfer("wr_id", 1'b1, 10'h000, 32'h1234_5678, 32'h0, 1'b1, 3, 1'b0);
        xfer("rd_id", 1'b0, 10'h000, 32'h0, ID_WORD, 1'b0, 3, 1'b0);
        xfer("rd_mis", 1'b0, 10'h102, 32'h0, 32'h0, 1'b1, 3, 1'b0);
        xfer("rd_oor", 1'b0, 10'h100, 32'h0, 32'h0, 1'b1, 3, 1'b0);
        xfer("wr_oor", 1'b1, 10'h100, 32'h55, 32'h0, 1'b1, 3, 1'b0);
        xfer("wr_mis", 1'b1, 10'h016, 32'h77, 32'h0, 1'b1, 3, 1'b0);
        xfer("rd_10b", 1'b0, 10'h010, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 1'b0);
        xfer("rd_id_b", 1'b0, 10'h000, 32'h0, ID_WORD, 1'b0, 3, 1'b0);
        xfer("rd_14_c", 1'b0, 10'h014, 32'h0, 32'h0, 1'b0, 3, 1'b0);

        // Bus changes during ACCESS must not redirect the latched transfer.
        xfer("wr_14_scr", 1'b1, 10'h014, 32'hA5A5_0F0F, 32'h0, 1'b0, 3, 1'b1);
        xfer("rd_14", 1'b0, 10'h014, 32'h0, 32'hA5A5_0F0F, 1'b0, 3, 1'b0);
        xfer("rd_18", 1'b0, 10'h018, 32'h0, 32'h0, 1'b0, 3, 1'b0);

        // Abort: PSEL dropped in the second ACCESS cycle.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h020; pwdata = 32'hCAFE_F00D;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        @(negedge pclk);
        chk("abort_acc1_pready", 32'(pready), 32'd0);
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        chk("abort_pready", 32'(pready), 32'd0);
        @(posedge pclk); #1;
        chk("abort_state", 32'(dbg), 32'(S_IDLE));
        @(negedge pclk);
        chk("abort_pready2", 32'(pready), 32'd0);
        @(posedge pclk); #1;
        xfer("rd_20_abort", 1'b0, 10'h020, 32'h0, 32'h0, 1'b0, 3, 1'b0);

        // Reset asserted in the completion ACCESS cycle of a write.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h020; pwdata = 32'hCAFE_F00D;
        @(posedge pclk); #1;
        penable = 1'b1;
        repeat (3) begin
            @(posedge pclk); #1;
        end
        preset = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b0; psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        chk("rstmid_state", 32'(dbg), 32'(S_IDLE));
        chk("rstmid_pready", 32'(pready), 32'd0);
        @(posedge pclk); #1;
        xfer("rd_20_rst", 1'b0, 10'h020, 32'h0, 32'h0, 1'b0, 3, 1'b0);
        xfer("rd_10_rst", 1'b0, 10'h010, 32'h0, 32'h0, 1'b0, 3, 1'b0);

        // Back-to-back writes, two wait states.
        xfer("b2b_wr_08", 1'b1, 10'h008, 32'h1111_2222, 32'h0, 1'b0, 3, 1'b0);
        xfer("b2b_wr_0c", 1'b1, 10'h00C, 32'h3333_4444, 32'h0, 1'b0, 3, 1'b0);
        xfer("b2b_rd_08", 1'b0, 10'h008, 32'h0, 32'h1111_2222, 1'b0, 3, 1'b0);
        xfer("b2b_rd_0c", 1'b0, 10'h00C, 32'h0, 32'h3333_4444, 1'b0, 3, 1'b0);

        // Zero-wait instance.
        use0 = 1'b1;
        @(posedge pclk); #1;
        xfer("w0_wr_08", 1'b1, 10'h008, 32'hAAAA_0008, 32'h0, 1'b0, 1, 1'b0);
        xfer("w0_wr_0c", 1'b1, 10'h00C, 32'hBBBB_000C, 32'h0, 1'b0, 1, 1'b0);
        xfer("w0_rd_08", 1'b0, 10'h008, 32'h0, 32'hAAAA_0008, 1'b0, 1, 1'b0);
        xfer("w0_rd_0c", 1'b0, 10'h00C, 32'h0, 32'hBBBB_000C, 1'b0, 1, 1'b0);
        xfer("w0_wr_id", 1'b1, 10'h000, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 1'b0);
        xfer("w0_rd_id", 1'b0, 10'h000, 32'h0, ID_WORD, 1'b0, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
